hilo_ctrl: RTL and testbench
============================

// Module: hilo_ctrl
// PURPOSE
//  Issue/writeback stage for the iterative multiplier in the EX stage of the pipelined MIPS core.
//  - Upstream: latches operands for MULT/MULTU and drives the multiplier start sequence.
//  - Downstream: waits for the multiplier's completed flag and captures hi/lo into architectural HI/LO.
//  - Serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a product is outstanding.
// PARAMETERS
//  TIMEOUT  80  cycles in WAIT before the watchdog aborts the multiply (must exceed the multiplier's worst-case latency)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  MultStartE in   1   MULT/MULTU in EX this cycle
//  MultSgnE   in   1   1 = MULT (signed), 0 = MULTU
//  SrcAE      in   32  rs operand; also the MTHI/MTLO data
//  SrcBE      in   32  rt operand
//  MoveHiE    in   1   MTHI in EX
//  MoveLoE    in   1   MTLO in EX
//  ReadHiE    in   1   MFHI in EX
//  ReadLoE    in   1   MFLO in EX
//  MulHi      in   32  multiplier hi result
//  MulLo      in   32  multiplier lo result
//  MulDone    in   1   multiplier completed flag
//  MultE      out  1   multiplier enable
//  MultSgn    out  1   latched signedness to the multiplier
//  MultA      out  32  latched operand A to the multiplier
//  MultB      out  32  latched operand B to the multiplier
//  MulRst     out  1   one-cycle start/clear pulse to the multiplier's rst input
//  HiLoOutE   out  32  MFHI/MFLO read data
//  StallHL    out  1   stall request to hazard unit
//  Busy       out  1   multiply outstanding (LAUNCH or WAIT)
//  MulErr     out  1   sticky watchdog flag; cleared only by rst
// BEHAVIOUR
//  Reset (async)
//  - State -> IDLE.
//  - HI, LO, MultA, MultB, counter -> 0.
//  - MultSgn, MultE, MulRst, StallHL, Busy, MulErr -> 0.
//  - HiLoOutE = 0, because HI and LO are 0.
//  - Reset mid-multiply discards the product; HI/LO stay 0.
//  FSM states
//  - IDLE
//    - MultStartE: latch SrcAE->MultA, SrcBE->MultB, MultSgnE->MultSgn; go to LAUNCH.
//    - Else MTHI writes HI <= SrcAE; MTLO writes LO <= SrcAE.
//  - LAUNCH (exactly 1 cycle)
//    - MulRst=1, MultE=1, counter<=0; go to WAIT.
//    - MulDone is ignored in this state.
//  - WAIT
//    - MultE=1, counter++ each cycle.
//    - First cycle with MulDone=1: go to WBACK.
//    - If counter reaches TIMEOUT first: MulErr<=1, go to IDLE, HI/LO unchanged.
//  - WBACK (1 cycle)
//    - HI<=MulHi, LO<=MulLo; MultE=0; go to IDLE.
//  - MultE deasserts in the cycle after capture.
//  Read path and stalls
//  - HiLoOutE = ReadHiE ? HI : LO.
//  - Combinational from registers; no bypass from MulHi/MulLo.
//  - StallHL=1 in LAUNCH, WAIT and WBACK when any of MultStartE, MoveHiE, MoveLoE, ReadHiE, ReadLoE is high.
//  - A stalled instruction holds its inputs and is serviced in the first IDLE cycle.
//  - A stalled MFHI therefore reads the new product.
//  - StallHL=0 in IDLE; back-to-back MULT costs one IDLE cycle between products.
//  - Busy = (state==LAUNCH || state==WAIT).
//  Latency
//  - MultStartE to HI/LO valid = 3 + multiplier latency cycles.
//  Simultaneous events
//  - MultStartE with MoveHiE/MoveLoE in IDLE: MultStartE wins; the moves are ignored (illegal encoding).
//  - MulDone high in IDLE: ignored.
//  - Only 64-bit product pairs are captured; MulHi/MulLo sign handling is the multiplier's responsibility.
// TESTING
//  1. MULTU 51*51 -> after MulDone, HI=0x0, LO=0x00000A29; MulRst pulses exactly once; Busy clears.
//  2. MULT 0xFFFFFFFD * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  3. MFLO issued 2 cycles after MULT -> StallHL=1 until WBACK; first IDLE returns the new LO.
//  4. MTHI 0xDEADBEEF, then MFHI -> HiLoOutE=0xDEADBEEF, no stall.
//  5. rst asserted mid-WAIT -> state IDLE, HI=LO=0, MultE=0 immediately (async).
//  6. MulDone tied 0 -> after TIMEOUT cycles MulErr=1, state IDLE, HI/LO unchanged.

Source files
------------

// File: rtl/hilo_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_ctrl
//   Issue/writeback stage for the iterative multiplier in the EX stage of the
//   pipelined MIPS core. Latches MULT/MULTU operands, sequences the multiplier
//   (one start/clear pulse, then enable until done), captures the 64-bit
//   product into the architectural HI/LO registers and serves MFHI/MFLO/MTHI/
//   MTLO. While a product is outstanding any HI/LO instruction is stalled and
//   is serviced in the first IDLE cycle, so a stalled MFHI/MFLO sees the new
//   product. A watchdog aborts a multiply that never completes.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   MultStartE        MULT/MULTU in EX          MultSgnE   1 = signed MULT
//   SrcAE, SrcBE      rs / rt operands (SrcAE also carries MTHI/MTLO data)
//   MoveHiE, MoveLoE  MTHI / MTLO in EX         ReadHiE, ReadLoE  MFHI / MFLO
//   MulHi, MulLo      multiplier product        MulDone    multiplier done flag
//   MultE             multiplier enable         MulRst     one-cycle start pulse
//   MultSgn, MultA, MultB  latched signedness and operands to the multiplier
//   HiLoOutE          MFHI/MFLO read data (HI when ReadHiE, else LO)
//   StallHL           stall request to the hazard unit
//   Busy              multiply outstanding (LAUNCH or WAIT)
//   MulErr            sticky watchdog flag, cleared only by rst
// -----------------------------------------------------------------------------
module hilo_ctrl #(
  parameter int TIMEOUT = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MultStartE,
  input  logic        MultSgnE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        MoveHiE,
  input  logic        MoveLoE,
  input  logic        ReadHiE,
  input  logic        ReadLoE,
  input  logic [31:0] MulHi,
  input  logic [31:0] MulLo,
  input  logic        MulDone,
  output logic        MultE,
  output logic        MultSgn,
  output logic [31:0] MultA,
  output logic [31:0] MultB,
  output logic        MulRst,
  output logic [31:0] HiLoOutE,
  output logic        StallHL,
  output logic        Busy,
  output logic        MulErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_WBACK  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   counter;
  logic [31:0]     hi;
  logic [31:0]     lo;
  logic            timeout_hit;
  logic            hl_request;

  // counter holds the number of WAIT cycles already spent, so the abort
  // decision is taken in the TIMEOUT-th WAIT cycle.
  assign timeout_hit = (counter == CW'(TIMEOUT - 1));

  // Any instruction that touches HI/LO or the multiplier.
  assign hl_request = MultStartE | MoveHiE | MoveLoE | ReadHiE | ReadLoE;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. MulDone only matters in WAIT and wins over the watchdog
  // when both occur in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (MultStartE) state_nxt = S_LAUNCH;
        else            state_nxt = S_IDLE;
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (MulDone)          state_nxt = S_WBACK;
        else if (timeout_hit) state_nxt = S_IDLE;
        else                  state_nxt = S_WAIT;
      end
      S_WBACK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: operand latch, HI/LO, watchdog counter, error flag.
  // In IDLE a MULT start takes precedence over MTHI/MTLO (illegal combination).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      MultA   <= 32'd0;
      MultB   <= 32'd0;
      MultSgn <= 1'b0;
      counter <= '0;
      MulErr  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MultStartE) begin
            MultA   <= SrcAE;
            MultB   <= SrcBE;
            MultSgn <= MultSgnE;
          end else begin
            if (MoveHiE) hi <= SrcAE;
            if (MoveLoE) lo <= SrcAE;
          end
        end
        S_LAUNCH: begin
          counter <= '0;
        end
        S_WAIT: begin
          counter <= counter + CW'(1);
          if (!MulDone && timeout_hit) MulErr <= 1'b1;
        end
        S_WBACK: begin
          hi <= MulHi;
          lo <= MulLo;
        end
        default: begin
          counter <= '0;
        end
      endcase
    end
  end

  // Control outputs are pure decodes of the state register, so an async reset
  // drops them immediately.
  assign MulRst  = (state == S_LAUNCH);
  assign MultE   = (state == S_LAUNCH) || (state == S_WAIT);
  assign Busy    = (state == S_LAUNCH) || (state == S_WAIT);
  assign StallHL = (state != S_IDLE) && hl_request;

  // Read data comes from the architectural registers only; no bypass from
  // the multiplier outputs.
  assign HiLoOutE = ReadHiE ? hi : lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_ctrl
//   Directed self-checking bench for hilo_ctrl. The bench plays the role of
//   the multiplier by driving MulDone/MulHi/MulLo with hand-computed products.
//   Inputs are driven 1 ns after the rising edge; outputs are checked a
//   further 1 ns later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_hilo_ctrl;

  logic        clk;
  logic        rst;
  logic        MultStartE;
  logic        MultSgnE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        MoveHiE;
  logic        MoveLoE;
  logic        ReadHiE;
  logic        ReadLoE;
  logic [31:0] MulHi;
  logic [31:0] MulLo;
  logic        MulDone;
  logic        MultE;
  logic        MultSgn;
  logic [31:0] MultA;
  logic [31:0] MultB;
  logic        MulRst;
  logic [31:0] HiLoOutE;
  logic        StallHL;
  logic        Busy;
  logic        MulErr;

  int vecs = 0;
  int errs = 0;
  int mulrst_cnt = 0;

  hilo_ctrl #(.TIMEOUT(80)) dut (
    .clk(clk), .rst(rst),
    .MultStartE(MultStartE), .MultSgnE(MultSgnE),
    .SrcAE(SrcAE), .SrcBE(SrcBE),
    .MoveHiE(MoveHiE), .MoveLoE(MoveLoE),
    .ReadHiE(ReadHiE), .ReadLoE(ReadLoE),
    .MulHi(MulHi), .MulLo(MulLo), .MulDone(MulDone),
    .MultE(MultE), .MultSgn(MultSgn), .MultA(MultA), .MultB(MultB),
    .MulRst(MulRst), .HiLoOutE(HiLoOutE), .StallHL(StallHL),
    .Busy(Busy), .MulErr(MulErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which the start/clear pulse is high.
  always @(negedge clk) begin
    if (MulRst === 1'b1) mulrst_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a complete multiply; the product appears after 'waits' WAIT cycles.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [31:0] phi, input logic [31:0] plo, input int waits);
    tick(); MultStartE = 1'b1; SrcAE = a; SrcBE = b; MultSgnE = sgn;
    tick(); MultStartE = 1'b0; SrcAE = 32'h0; SrcBE = 32'h0;   // LAUNCH
    tick();                                                    // first WAIT
    repeat (waits) tick();
    MulHi = phi; MulLo = plo; MulDone = 1'b1;
    tick(); MulDone = 1'b0;                                    // WBACK
    tick();                                                    // IDLE
    MulHi = 32'hBAD0BAD0; MulLo = 32'hBAD1BAD1;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (MultE !== 1'b0) begin errs++; $display("FAIL rst_multe got %0b want 0", MultE); end
    vecs++; if (MulRst !== 1'b0) begin errs++; $display("FAIL rst_mulrst got %0b want 0", MulRst); end
    vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %0b want 0", Busy); end
    vecs++; if (MulErr !== 1'b0) begin errs++; $display("FAIL rst_mulerr got %0b want 0", MulErr); end
    vecs++; if (MultA !== 32'h0 || MultB !== 32'h0 || MultSgn !== 1'b0) begin errs++; $display("FAIL rst_operands got %h %h %0b want 0 0 0", MultA, MultB, MultSgn); end
    ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h0) begin errs++; $display("FAIL rst_hi got %h want 00000000", HiLoOutE); end
    vecs++; if (StallHL !== 1'b0) begin errs++; $display("FAIL rst_stall got %0b want 0", StallHL); end
    ReadHiE = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu();
    int p;
    p = mulrst_cnt;
    tick(); MultStartE = 1'b1; SrcAE = 32'd51; SrcBE = 32'd51; MultSgnE = 1'b0; #1;
    vecs++; if (StallHL !== 1'b0 || Busy !== 1'b0) begin errs++; $display("FAIL t1_idle got stall=%0b busy=%0b want 0 0", StallHL, Busy); end
    tick(); MultStartE = 1'b0; SrcAE = 32'h12345678; SrcBE = 32'h9ABCDEF0; MulHi = 32'h0; MulLo = 32'h00000A29; #1;
    vecs++; if (MulRst !== 1'b1 || MultE !== 1'b1 || Busy !== 1'b1) begin errs++; $display("FAIL t1_launch got mulrst=%0b multe=%0b busy=%0b want 1 1 1", MulRst, MultE, Busy); end
    vecs++; if (MultA !== 32'd51 || MultB !== 32'd51 || MultSgn !== 1'b0) begin errs++; $display("FAIL t1_latch got %h %h %0b want 00000033 00000033 0", MultA, MultB, MultSgn); end
    tick(); #1;
    vecs++; if (MulRst !== 1'b0 || MultE !== 1'b1 || Busy !== 1'b1) begin errs++; $display("FAIL t1_wait got mulrst=%0b multe=%0b busy=%0b want 0 1 1", MulRst, MultE, Busy); end
    repeat (3) tick();
    MulDone = 1'b1;
    tick(); MulDone = 1'b0; #1;
    vecs++; if (Busy !== 1'b0 || MultE !== 1'b0) begin errs++; $display("FAIL t1_wback got busy=%0b multe=%0b want 0 0", Busy, MultE); end
    tick(); ReadLoE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h00000A29) begin errs++; $display("FAIL t1_lo got %h want 00000a29", HiLoOutE); end
    ReadLoE = 1'b0; ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h0) begin errs++; $display("FAIL t1_hi got %h want 00000000", HiLoOutE); end
    ReadHiE = 1'b0;
    MulHi = 32'hBAD0BAD0; MulLo = 32'hBAD1BAD1;
    vecs++; if (mulrst_cnt - p !== 1) begin errs++; $display("FAIL t1_pulses got %0d want 1", mulrst_cnt - p); end
  endtask

  task automatic test_mult_signed();
    run_mult(32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 2);
    vecs++; if (MultA !== 32'hFFFFFFFD || MultB !== 32'd5 || MultSgn !== 1'b1) begin errs++; $display("FAIL t2_latch got %h %h %0b want fffffffd 00000005 1", MultA, MultB, MultSgn); end
    ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'hFFFFFFFF) begin errs++; $display("FAIL t2_hi got %h want ffffffff", HiLoOutE); end
    ReadHiE = 1'b0; ReadLoE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'hFFFFFFF1) begin errs++; $display("FAIL t2_lo got %h want fffffff1", HiLoOutE); end
    ReadLoE = 1'b0;
  endtask

  task automatic test_stalled_read();
    tick(); MultStartE = 1'b1; SrcAE = 32'd7; SrcBE = 32'd6; MultSgnE = 1'b0;
    tick(); MultStartE = 1'b0;                                   // LAUNCH
    tick(); ReadLoE = 1'b1; MulHi = 32'h0; MulLo = 32'h2A; #1;    // WAIT, MFLO arrives
    vecs++; if (StallHL !== 1'b1) begin errs++; $display("FAIL t3_stall_wait got %0b want 1", StallHL); end
    vecs++; if (HiLoOutE !== 32'hFFFFFFF1) begin errs++; $display("FAIL t3_nobypass got %h want fffffff1", HiLoOutE); end
    tick(); MulDone = 1'b1; #1;
    vecs++; if (StallHL !== 1'b1) begin errs++; $display("FAIL t3_stall_done got %0b want 1", StallHL); end
    tick(); MulDone = 1'b0; #1;                                   // WBACK
    vecs++; if (StallHL !== 1'b1) begin errs++; $display("FAIL t3_stall_wback got %0b want 1", StallHL); end
    tick(); #1;                                                   // IDLE
    vecs++; if (StallHL !== 1'b0) begin errs++; $display("FAIL t3_release got %0b want 0", StallHL); end
    vecs++; if (HiLoOutE !== 32'h0000002A) begin errs++; $display("FAIL t3_newlo got %h want 0000002a", HiLoOutE); end
    ReadLoE = 1'b0; MulLo = 32'hBAD1BAD1;
  endtask

  task automatic test_move();
    tick(); MoveHiE = 1'b1; SrcAE = 32'hDEADBEEF; #1;
    vecs++; if (StallHL !== 1'b0) begin errs++; $display("FAIL t4_mthi_stall got %0b want 0", StallHL); end
    tick(); MoveHiE = 1'b0; MoveLoE = 1'b1; SrcAE = 32'h0BADF00D;
    tick(); MoveLoE = 1'b0; SrcAE = 32'h0; ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'hDEADBEEF || StallHL !== 1'b0) begin errs++; $display("FAIL t4_mfhi got %h stall=%0b want deadbeef 0", HiLoOutE, StallHL); end
    ReadHiE = 1'b0; ReadLoE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h0BADF00D) begin errs++; $display("FAIL t4_mflo got %h want 0badf00d", HiLoOutE); end
    ReadLoE = 1'b0;
  endtask

  task automatic test_conflicts();
    // MULT with MTHI in IDLE: the move is dropped.
    tick(); MultStartE = 1'b1; MoveHiE = 1'b1; SrcAE = 32'h11111111; SrcBE = 32'd2; MultSgnE = 1'b0;
    tick(); MultStartE = 1'b0; MoveHiE = 1'b0; ReadHiE = 1'b1;    // LAUNCH
    MulDone = 1'b1; MulHi = 32'h0; MulLo = 32'h22222222; #1;
    vecs++; if (HiLoOutE !== 32'hDEADBEEF) begin errs++; $display("FAIL cf_move_ignored got %h want deadbeef", HiLoOutE); end
    ReadHiE = 1'b0;
    tick(); #1;                                                   // must be WAIT despite MulDone in LAUNCH
    vecs++; if (Busy !== 1'b1) begin errs++; $display("FAIL cf_launch_done got busy=%0b want 1", Busy); end
    tick(); MulDone = 1'b0; #1;                                   // WBACK
    tick(); ReadLoE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h22222222) begin errs++; $display("FAIL cf_lo got %h want 22222222", HiLoOutE); end
    ReadLoE = 1'b0;
    // MulDone in IDLE must not touch HI/LO.
    MulDone = 1'b1; MulHi = 32'h55555555; MulLo = 32'h66666666;
    tick(); tick(); MulDone = 1'b0; ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h0 || Busy !== 1'b0) begin errs++; $display("FAIL cf_idle_done got %h busy=%0b want 00000000 0", HiLoOutE, Busy); end
    ReadHiE = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick(); MultStartE = 1'b1; SrcAE = 32'd3; SrcBE = 32'd4; MultSgnE = 1'b0;
    tick(); SrcAE = 32'd9; SrcBE = 32'd10; #1;                   // LAUNCH, next MULT held
    vecs++; if (StallHL !== 1'b1 || MultA !== 32'd3) begin errs++; $display("FAIL bb_launch got stall=%0b a=%h want 1 00000003", StallHL, MultA); end
    tick(); MulHi = 32'h0; MulLo = 32'd12; MulDone = 1'b1; #1;   // WAIT
    vecs++; if (StallHL !== 1'b1 || MultA !== 32'd3) begin errs++; $display("FAIL bb_wait got stall=%0b a=%h want 1 00000003", StallHL, MultA); end
    tick(); MulDone = 1'b0; #1;                                   // WBACK
    tick(); #1;                                                   // IDLE gap
    vecs++; if (StallHL !== 1'b0 || Busy !== 1'b0) begin errs++; $display("FAIL bb_gap got stall=%0b busy=%0b want 0 0", StallHL, Busy); end
    tick(); MultStartE = 1'b0; ReadLoE = 1'b1; #1;               // second LAUNCH
    vecs++; if (MulRst !== 1'b1 || MultA !== 32'd9 || MultB !== 32'd10) begin errs++; $display("FAIL bb_second got rst=%0b a=%h b=%h want 1 00000009 0000000a", MulRst, MultA, MultB); end
    vecs++; if (HiLoOutE !== 32'd12) begin errs++; $display("FAIL bb_first_lo got %h want 0000000c", HiLoOutE); end
    tick(); MulLo = 32'd90; MulDone = 1'b1;
    tick(); MulDone = 1'b0;
    tick(); #1;
    vecs++; if (HiLoOutE !== 32'd90) begin errs++; $display("FAIL bb_second_lo got %h want 0000005a", HiLoOutE); end
    ReadLoE = 1'b0; MulLo = 32'hBAD1BAD1;
  endtask

  task automatic test_timeout();
    tick(); MoveHiE = 1'b1; SrcAE = 32'hAAAA0001;
    tick(); MoveHiE = 1'b0; MoveLoE = 1'b1; SrcAE = 32'h55550002;
    tick(); MoveLoE = 1'b0; MultStartE = 1'b1; SrcAE = 32'd1; SrcBE = 32'd1; MulDone = 1'b0;
    tick(); MultStartE = 1'b0;                                    // LAUNCH
    repeat (80) tick();                                           // 80th WAIT cycle
    vecs++; if (Busy !== 1'b1 || MulErr !== 1'b0) begin errs++; $display("FAIL to_last_wait got busy=%0b err=%0b want 1 0", Busy, MulErr); end
    tick();
    vecs++; if (Busy !== 1'b0 || MultE !== 1'b0 || MulErr !== 1'b1) begin errs++; $display("FAIL to_abort got busy=%0b multe=%0b err=%0b want 0 0 1", Busy, MultE, MulErr); end
    ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'hAAAA0001) begin errs++; $display("FAIL to_hi got %h want aaaa0001", HiLoOutE); end
    ReadHiE = 1'b0; ReadLoE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h55550002) begin errs++; $display("FAIL to_lo got %h want 55550002", HiLoOutE); end
    ReadLoE = 1'b0;
    run_mult(32'd2, 32'd2, 1'b0, 32'h0, 32'd4, 1);
    vecs++; if (MulErr !== 1'b1) begin errs++; $display("FAIL to_sticky got %0b want 1", MulErr); end
  endtask

  task automatic test_async_reset();
    tick(); MultStartE = 1'b1; SrcAE = 32'd100; SrcBE = 32'd200; MultSgnE = 1'b1;
    tick(); MultStartE = 1'b0;                                    // LAUNCH
    tick(); tick();                                               // WAIT
    #2; rst = 1'b1; #1;
    vecs++; if (MultE !== 1'b0 || Busy !== 1'b0 || MulErr !== 1'b0) begin errs++; $display("FAIL ar_ctrl got multe=%0b busy=%0b err=%0b want 0 0 0", MultE, Busy, MulErr); end
    vecs++; if (MultA !== 32'h0 || MultSgn !== 1'b0) begin errs++; $display("FAIL ar_operands got %h %0b want 00000000 0", MultA, MultSgn); end
    ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h0) begin errs++; $display("FAIL ar_hi got %h want 00000000", HiLoOutE); end
    ReadHiE = 1'b0; #1;
    vecs++; if (HiLoOutE !== 32'h0) begin errs++; $display("FAIL ar_lo got %h want 00000000", HiLoOutE); end
    MulDone = 1'b1; MulHi = 32'h77777777; MulLo = 32'h88888888;
    @(negedge clk); rst = 1'b0;
    tick(); MulDone = 1'b0; tick(); ReadHiE = 1'b1; #1;
    vecs++; if (HiLoOutE !== 32'h0 || Busy !== 1'b0) begin errs++; $display("FAIL ar_discard got %h busy=%0b want 00000000 0", HiLoOutE, Busy); end
    ReadHiE = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    MultStartE = 1'b0; MultSgnE = 1'b0; SrcAE = 32'h0; SrcBE = 32'h0;
    MoveHiE = 1'b0; MoveLoE = 1'b0; ReadHiE = 1'b0; ReadLoE = 1'b0;
    MulHi = 32'h0; MulLo = 32'h0; MulDone = 1'b0;
    test_reset();
    test_multu();
    test_mult_signed();
    test_stalled_read();
    test_move();
    test_conflicts();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
